game_sequencer: RTL and testbench

Central game-flow controller for the pong datapath. It divides the system clock into game ticks and issues one-cycle update strobes to the ball and paddle blocks only while play is live. It sequences serve, play, pause, point and game-over phases, and keeps both players' scores. It consumes the ball block's `win` flags and drives the ball re-centre strobe, so ball and paddles never free-run on the raw clock.

---
 rtl/game_sequencer.sv | 171 +++++++++++++++++
 tb/tb_game_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: central game-flow controller for the pong datapath.
// Divides the clock into game ticks, gates ball/paddle update strobes to live
// play, sequences serve/play/pause/point/over phases and keeps both scores.
module game_sequencer #(
  parameter int TICK_DIV    = 4,
  parameter int SCORE_WIDTH = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 30,
  parameter int POINT_TICKS = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic [1:0]             win,
  output logic                   update_en,
  output logic                   ball_reset,
  output logic                   serve_dir,
  output logic [SCORE_WIDTH-1:0] score1,
  output logic [SCORE_WIDTH-1:0] score2,
  output logic [2:0]             state,
  output logic                   game_over,
  output logic [1:0]             winner
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]          TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL   = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [7:0]             SERVE_DLY = 8'(SERVE_TICKS);
  localparam logic [7:0]             POINT_DLY = 8'(POINT_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_POINT  = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          tick_cnt_q;
  logic [7:0]             dly_q;
  logic                   start_q;
  logic                   start_vld_q;
  logic                   update_en_q;
  logic                   ball_reset_q;
  logic                   serve_dir_q;
  logic [SCORE_WIDTH-1:0] score1_q;
  logic [SCORE_WIDTH-1:0] score2_q;
  logic                   game_over_q;
  logic [1:0]             winner_q;

  logic tick;
  logic start_rise;
  logic win_reached;

  assign tick        = (tick_cnt_q == TICK_LAST);
  // start_vld_q keeps a button already held across reset release from
  // looking like a fresh press on the first clock.
  assign start_rise  = start & ~start_q & start_vld_q;
  assign win_reached = (score1_q == WIN_VAL) || (score2_q == WIN_VAL);

  // Free-running game tick divider, runs in every state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // Start button edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q     <= 1'b0;
      start_vld_q <= 1'b0;
    end else begin
      start_q     <= start;
      start_vld_q <= 1'b1;
    end
  end

  // Game-flow FSM with registered strobes, scores and winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      update_en_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      score1_q     <= '0;
      score2_q     <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      ball_reset_q <= 1'b0;
      update_en_q  <= tick && (state_q == ST_PLAY) && !pause && (win == 2'b00);
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            score1_q     <= '0;
            score2_q     <= '0;
            winner_q     <= 2'b00;
            game_over_q  <= 1'b0;
            ball_reset_q <= 1'b1;
            dly_q        <= SERVE_DLY;
            state_q      <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (tick && !pause) begin
            if (dly_q == 8'd0) state_q <= ST_PLAY;
            else               dly_q   <= dly_q - 8'd1;
          end
        end
        ST_PLAY: begin
          if (win == 2'b01) begin
            score1_q    <= score1_q + 1'b1;
            serve_dir_q <= 1'b1;
            dly_q       <= POINT_DLY;
            state_q     <= ST_POINT;
          end else if (win == 2'b10) begin
            score2_q    <= score2_q + 1'b1;
            serve_dir_q <= 1'b0;
            dly_q       <= POINT_DLY;
            state_q     <= ST_POINT;
          end else if (win == 2'b11) begin
            dly_q       <= POINT_DLY;
            state_q     <= ST_POINT;
          end else if (pause) begin
            state_q     <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!pause) state_q <= ST_PLAY;
        end
        ST_POINT: begin
          if (tick) begin
            if (dly_q != 8'd0) begin
              dly_q <= dly_q - 8'd1;
            end else if (win_reached) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= (score1_q == WIN_VAL) ? 2'b01 : 2'b10;
            end else begin
              ball_reset_q <= 1'b1;
              dly_q        <= SERVE_DLY;
              state_q      <= ST_SERVE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign update_en  = update_en_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign state      = state_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, SERVE_TICKS=2,
// POINT_TICKS=1, WIN_SCORE=3. Inputs change and outputs are sampled on the
// falling edge; N<k> in comments is the k-th falling edge after reset release.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] win = 2'b00;
  logic       update_en, ball_reset, serve_dir, game_over;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fails  = 0;

  game_sequencer #(
    .TICK_DIV(4), .SCORE_WIDTH(4), .WIN_SCORE(3), .SERVE_TICKS(2), .POINT_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .win(win),
    .update_en(update_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .state(state),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] s, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({update_en, ball_reset, serve_dir, score1, score2, state, game_over, winner} !== 17'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b want all zero",
               {update_en, ball_reset, serve_dir, score1, score2, state, game_over, winner});
    end
    rst = 1'b1;  // N0
  endtask

  task automatic test_start;
    @(negedge clk); start = 1'b1;  // N1
    @(negedge clk); start = 1'b0;  // N2
    n_checks++;
    if (ball_reset !== 1'b1 || state !== 3'd1) begin
      n_fails++;
      $display("FAIL start_serve: got ball_reset=%b state=%0d want 1/1", ball_reset, state);
    end
    @(negedge clk);  // N3
    n_checks++;
    if (ball_reset !== 1'b0) begin
      n_fails++;
      $display("FAIL start_ball_reset_width: got %b want 0", ball_reset);
    end
    repeat (8) @(negedge clk);  // N11
    n_checks++;
    if (state !== 3'd1) begin
      n_fails++;
      $display("FAIL serve_len_early: got state=%0d want 1", state);
    end
    @(negedge clk);  // N12
    n_checks++;
    if (state !== 3'd2) begin
      n_fails++;
      $display("FAIL serve_to_play: got state=%0d want 2", state);
    end
    repeat (3) @(negedge clk);  // N15
    n_checks++;
    if (update_en !== 1'b0) begin
      n_fails++;
      $display("FAIL update_before_tick: got %b want 0", update_en);
    end
    @(negedge clk);  // N16
    n_checks++;
    if (update_en !== 1'b1) begin
      n_fails++;
      $display("FAIL update_first: got %b want 1", update_en);
    end
    @(negedge clk);  // N17
    n_checks++;
    if (update_en !== 1'b0) begin
      n_fails++;
      $display("FAIL update_one_cycle: got %b want 0", update_en);
    end
    repeat (3) @(negedge clk);  // N20
    n_checks++;
    if (update_en !== 1'b1) begin
      n_fails++;
      $display("FAIL update_period: got %b want 1", update_en);
    end
  endtask

  task automatic test_point_p1;
    win = 2'b01;  // held N20..N24
    @(negedge clk);  // N21
    n_checks++;
    if (score1 !== 4'd1 || state !== 3'd4 || serve_dir !== 1'b1) begin
      n_fails++;
      $display("FAIL point_p1: got score1=%0d state=%0d dir=%b want 1/4/1", score1, state, serve_dir);
    end
    repeat (3) @(negedge clk);  // N24
    n_checks++;
    if (update_en !== 1'b0) begin
      n_fails++;
      $display("FAIL update_in_point: got %b want 0", update_en);
    end
    @(negedge clk); win = 2'b00;  // N25
    n_checks++;
    if (score1 !== 4'd1) begin
      n_fails++;
      $display("FAIL point_once: got score1=%0d want 1", score1);
    end
    repeat (2) @(negedge clk);  // N27
    n_checks++;
    if (state !== 3'd4) begin
      n_fails++;
      $display("FAIL point_len: got state=%0d want 4", state);
    end
    @(negedge clk);  // N28
    n_checks++;
    if (state !== 3'd1 || ball_reset !== 1'b1) begin
      n_fails++;
      $display("FAIL point_reserve: got state=%0d ball_reset=%b want 1/1", state, ball_reset);
    end
  endtask

  task automatic test_pause;
    pause = 1'b1;  // N28: pause during SERVE freezes the delay
    repeat (8) @(negedge clk); pause = 1'b0;  // N36
    repeat (4) @(negedge clk);  // N40
    n_checks++;
    if (state !== 3'd1) begin
      n_fails++;
      $display("FAIL serve_pause_freeze: got state=%0d want 1", state);
    end
    repeat (7) @(negedge clk);  // N47
    n_checks++;
    if (state !== 3'd1) begin
      n_fails++;
      $display("FAIL serve_pause_late: got state=%0d want 1", state);
    end
    @(negedge clk);  // N48
    n_checks++;
    if (state !== 3'd2) begin
      n_fails++;
      $display("FAIL serve_pause_play: got state=%0d want 2", state);
    end
    pause = 1'b1;  // held N48..N57
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);  // N49..N58
      n_checks++;
      if (state !== 3'd3 || update_en !== 1'b0) begin
        n_fails++;
        $display("FAIL paused_%0d: got state=%0d update_en=%b want 3/0", i, state, update_en);
      end
      if (i == 4) win = 2'b10;
      if (i == 5) win = 2'b00;
      if (i == 9) pause = 1'b0;
    end
    @(negedge clk);  // N59
    n_checks++;
    if (state !== 3'd2 || score2 !== 4'd0) begin
      n_fails++;
      $display("FAIL unpause: got state=%0d score2=%0d want 2/0", state, score2);
    end
    @(negedge clk);  // N60
    n_checks++;
    if (update_en !== 1'b1) begin
      n_fails++;
      $display("FAIL update_resume: got %b want 1", update_en);
    end
  endtask

  task automatic test_win_pause;
    bit ok;
    win = 2'b10; pause = 1'b1;
    @(negedge clk);  // N61
    n_checks++;
    if (state !== 3'd4 || score2 !== 4'd1 || serve_dir !== 1'b0) begin
      n_fails++;
      $display("FAIL win_over_pause: got state=%0d score2=%0d dir=%b want 4/1/0", state, score2, serve_dir);
    end
    win = 2'b00; pause = 1'b0;
    wait_state(3'd2, 60, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fails++;
      $display("FAIL wait_play_1: got timeout want state 2");
    end
    win = 2'b11;
    @(negedge clk);
    n_checks++;
    if (state !== 3'd4 || score1 !== 4'd1 || score2 !== 4'd1 || serve_dir !== 1'b0) begin
      n_fails++;
      $display("FAIL double_win: got state=%0d s1=%0d s2=%0d dir=%b want 4/1/1/0",
               state, score1, score2, serve_dir);
    end
    win = 2'b00;
  endtask

  task automatic test_game_over;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      wait_state(3'd2, 80, ok);
      n_checks++;
      if (ok !== 1'b1) begin
        n_fails++;
        $display("FAIL wait_play_go%0d: got timeout want state 2", k);
      end
      win = 2'b10;
      @(negedge clk);
      win = 2'b00;
    end
    wait_state(3'd5, 80, ok);
    n_checks++;
    if (ok !== 1'b1 || game_over !== 1'b1 || winner !== 2'b10 || score2 !== 4'd3 || score1 !== 4'd1) begin
      n_fails++;
      $display("FAIL game_over: got ok=%b go=%b winner=%b s1=%0d s2=%0d want 1/1/10/1/3",
               ok, game_over, winner, score1, score2);
    end
    win = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (update_en !== 1'b0 || state !== 3'd5 || score1 !== 4'd1) begin
        n_fails++;
        $display("FAIL over_hold_%0d: got upd=%b state=%0d s1=%0d want 0/5/1", i, update_en, state, score1);
      end
    end
    win = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (state !== 3'd1 || ball_reset !== 1'b1 || {score1, score2, winner, game_over} !== 11'd0) begin
      n_fails++;
      $display("FAIL restart: got state=%0d br=%b s1=%0d s2=%0d winner=%b go=%b want 1/1/0/0/00/0",
               state, ball_reset, score1, score2, winner, game_over);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    wait_state(3'd2, 80, ok);
    win = 2'b01;
    @(negedge clk);
    win = 2'b00;
    n_checks++;
    if (ok !== 1'b1 || state !== 3'd4) begin
      n_fails++;
      $display("FAIL reach_point: got ok=%b state=%0d want 1/4", ok, state);
    end
    #2;
    rst = 1'b0;
    start = 1'b1;
    #1;
    n_checks++;
    if ({update_en, ball_reset, serve_dir, score1, score2, state, game_over, winner} !== 17'd0) begin
      n_fails++;
      $display("FAIL async_reset: got %b want all zero",
               {update_en, ball_reset, serve_dir, score1, score2, state, game_over, winner});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== 3'd0 || ball_reset !== 1'b0) begin
      n_fails++;
      $display("FAIL held_start_no_edge: got state=%0d br=%b want 0/0", state, ball_reset);
    end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (state !== 3'd1 || ball_reset !== 1'b1) begin
      n_fails++;
      $display("FAIL start_after_reset: got state=%0d br=%b want 1/1", state, ball_reset);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_point_p1();
    test_pause();
    test_win_pause();
    test_game_over();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
